// File: rtl/scoreboard_scan_ctrl_pkg.sv
// Shared definitions for the scoreboard digit-scan controller.
// Covers the slot-state encoding, the default timing and the digit-blanking rule.
package scoreboard_scan_ctrl_pkg;

  localparam int unsigned SCAN_DIV_DEFAULT = 50000;
  localparam int unsigned GUARD_DEFAULT    = 500;
  localparam int unsigned NUM_DIGITS       = 4;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } slot_state_e;

  // A digit is hidden when it is not valid BCD, or when leading-zero blanking
  // is enabled and this digit and every higher digit are zero. An invalid
  // nibble counts as nonzero, so the digits below it stay visible.
  function automatic logic digit_hidden(input logic [15:0] disp,
                                        input logic [1:0]  idx,
                                        input logic        lz_en);
    logic higher_zero;
    logic hidden;
    hidden      = (disp[{idx, 2'b00} +: 4] > 4'd9);
    higher_zero = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      if (disp[4*k +: 4] != 4'd0) begin
        higher_zero = 1'b0;
      end
      if ((k == int'(idx)) && lz_en && higher_zero) begin
        hidden = 1'b1;
      end
    end
    return hidden;
  endfunction

endpackage

// File: rtl/scoreboard_scan_ctrl_prescaler.sv
// Free-running modulo-DIV counter.
// wrap_o is high during the last count, so the next edge returns the counter to 0.
module scan_prescaler #(
  parameter int unsigned DIV = 8,
  parameter int unsigned CW  = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign wrap_o = (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scoreboard_scan_ctrl.sv
// Time-multiplexed 4-digit BCD scan controller with guard blanking,
// leading-zero suppression, and score updates that take effect only at frame boundaries.
module scoreboard_scan_ctrl
  import scoreboard_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT,
  parameter int unsigned GUARD    = GUARD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        score_load,
  input  logic [15:0] score_in,
  input  logic        lz_blank,
  output logic [1:0]  sel,
  output logic [3:0]  digit_bcd,
  output logic        digit_blank,
  output logic        update_pend,
  output logic        frame_tick
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam slot_state_e RESET_STATE = (GUARD == 0) ? ST_SHOW : ST_GUARD;

  logic [CW-1:0] cnt;
  logic          wrap;
  logic          boundary;

  slot_state_e state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic        frame_tick_q, frame_tick_d;
  logic        blank_q, blank_d;

  scan_prescaler #(
    .DIV (SCAN_DIV),
    .CW  (CW)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .cnt_o  (cnt),
    .wrap_o (wrap)
  );

  assign boundary = wrap && (sel_q == 2'd3);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    frame_tick_d = 1'b0;

    if (wrap) begin
      sel_d   = sel_q + 2'd1;
      state_d = RESET_STATE;
    end else if ((state_q == ST_GUARD) && ((32'(cnt) + 32'd1) >= GUARD)) begin
      state_d = ST_SHOW;
    end

    // The display register only moves on the last cycle of a frame, so each
    // frame shows one coherent score; a load in that same cycle bypasses pending.
    if (boundary) begin
      frame_tick_d = 1'b1;
      pend_valid_d = 1'b0;
      if (score_load) begin
        disp_d = score_in;
      end else if (pend_valid_q) begin
        disp_d = pend_q;
      end
    end else if (score_load) begin
      pend_d       = score_in;
      pend_valid_d = 1'b1;
    end

    // Blanking is precomputed from next-state values so the registered flag
    // lines up with the registered select and display.
    blank_d = (state_d == ST_GUARD) || digit_hidden(disp_d, sel_d, lz_blank);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RESET_STATE;
      sel_q        <= 2'd0;
      disp_q       <= 16'h0000;
      // NOTE: the pending data register is cleared as well, so a reset can
      // never leak a stale load into the first frame.
      pend_q       <= 16'h0000;
      pend_valid_q <= 1'b0;
      frame_tick_q <= 1'b0;
      blank_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      frame_tick_q <= frame_tick_d;
      blank_q      <= blank_d;
    end
  end

  assign sel         = sel_q;
  assign digit_bcd   = disp_q[{sel_q, 2'b00} +: 4];
  assign digit_blank = blank_q;
  assign update_pend = pend_valid_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_scoreboard_scan_ctrl.sv
// Directed bench for scoreboard_scan_ctrl with SCAN_DIV=8, GUARD=2.
// k counts cycles since reset release; sel and frame_tick are checked on every step.
module tb_scoreboard_scan_ctrl;

  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned GUARD    = 2;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        score_load = 1'b0;
  logic [15:0] score_in   = 16'h0000;
  logic        lz_blank   = 1'b0;
  logic [1:0]  sel;
  logic [3:0]  digit_bcd;
  logic        digit_blank;
  logic        update_pend;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;

  always #5 clk = ~clk;

  scoreboard_scan_ctrl #(
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .score_load  (score_load),
    .score_in    (score_in),
    .lz_blank    (lz_blank),
    .sel         (sel),
    .digit_bcd   (digit_bcd),
    .digit_blank (digit_blank),
    .update_pend (update_pend),
    .frame_tick  (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    check("sel", 32'(sel), 32'((k / 8) % 4));
    check("frame_tick", 32'(frame_tick), ((k % 32) == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_blank", 32'(digit_blank), 32'd1);
    check("rst_pend", 32'(update_pend), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_bcd", 32'(digit_bcd), 32'd0);
    rst_n = 1'b1;
    k     = 0;
  endtask

  // Walks one slot starting at its first cycle: guard blanking for cycles 0-1,
  // then blanking decided by exp_show for cycles 2-7.
  task automatic check_slot(input string tag, input logic [3:0] exp_bcd, input logic exp_show);
    for (int c = 0; c < int'(SCAN_DIV); c++) begin
      if (c < int'(GUARD)) check({tag, "_guard"}, 32'(digit_blank), 32'd1);
      else                 check({tag, "_blank"}, 32'(digit_blank), exp_show ? 32'd0 : 32'd1);
      check({tag, "_bcd"}, 32'(digit_bcd), 32'(exp_bcd));
      step();
    end
  endtask

  task automatic load(input logic [15:0] value);
    score_in   = value;
    score_load = 1'b1;
    step();
    score_load = 1'b0;
  endtask

  initial begin
    apply_reset(3);

    // Free-running scan after release.
    run_to(40);

    // Mid-frame load waits for the frame boundary.
    load(16'h1234);
    check("pend_after_load", 32'(update_pend), 32'd1);
    run_to(63);
    check("pend_before_wrap", 32'(update_pend), 32'd1);
    check("old_digit_kept", 32'(digit_bcd), 32'd0);
    step();
    check("pend_after_wrap", 32'(update_pend), 32'd0);
    check_slot("f1234_d0", 4'd4, 1'b1);
    check_slot("f1234_d1", 4'd3, 1'b1);
    check_slot("f1234_d2", 4'd2, 1'b1);
    check_slot("f1234_d3", 4'd1, 1'b1);

    // Leading-zero blanking on 0050, then disabled.
    run_to(100);
    lz_blank = 1'b1;
    load(16'h0050);
    run_to(128);
    check_slot("lz_d0", 4'd0, 1'b1);
    check_slot("lz_d1", 4'd5, 1'b1);
    check_slot("lz_d2", 4'd0, 1'b0);
    check_slot("lz_d3", 4'd0, 1'b0);
    lz_blank = 1'b0;
    check_slot("nolz_d0", 4'd0, 1'b1);
    check_slot("nolz_d1", 4'd5, 1'b1);
    check_slot("nolz_d2", 4'd0, 1'b1);
    check_slot("nolz_d3", 4'd0, 1'b1);

    // Invalid nibble is blanked and counts as nonzero for lower digits.
    lz_blank = 1'b1;
    run_to(200);
    load(16'h0A00);
    run_to(224);
    check_slot("inv_d0", 4'd0, 1'b1);
    check_slot("inv_d1", 4'd0, 1'b1);
    check_slot("inv_d2", 4'hA, 1'b0);
    check_slot("inv_d3", 4'd0, 1'b0);
    lz_blank = 1'b0;

    // Last write wins.
    run_to(260);
    load(16'h1111);
    run_to(270);
    load(16'h2222);
    run_to(287);
    check("pend_two_loads", 32'(update_pend), 32'd1);
    step();
    check("pend_two_cleared", 32'(update_pend), 32'd0);
    check_slot("lww_d0", 4'd2, 1'b1);
    check_slot("lww_d1", 4'd2, 1'b1);
    check_slot("lww_d2", 4'd2, 1'b1);
    check_slot("lww_d3", 4'd2, 1'b1);

    // Load on the boundary cycle applies directly.
    run_to(351);
    check("pend_pre_bypass", 32'(update_pend), 32'd0);
    load(16'h3456);
    check("pend_bypass", 32'(update_pend), 32'd0);
    check_slot("byp_d0", 4'd6, 1'b1);
    check_slot("byp_d1", 4'd5, 1'b1);
    check_slot("byp_d2", 4'd4, 1'b1);
    check_slot("byp_d3", 4'd3, 1'b1);

    // Reset with a load pending discards it.
    load(16'h9999);
    check("pend_before_rst", 32'(update_pend), 32'd1);
    run_to(389);
    apply_reset(2);
    check("pend_after_rst", 32'(update_pend), 32'd0);
    check_slot("rst_d0", 4'd0, 1'b1);
    check_slot("rst_d1", 4'd0, 1'b1);
    check_slot("rst_d2", 4'd0, 1'b1);
    check_slot("rst_d3", 4'd0, 1'b1);
    run_to(33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
